// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: tracks pending writes per register to gate issue,
// and arbitrates ALU/load writebacks onto a single registered register-file write port.
module rf_scoreboard #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  input  logic [4:0]         issue_rd,
  input  logic               issue_use_rs1,
  input  logic               issue_use_rs2,
  input  logic               issue_wr,
  output logic               issue_ready,
  input  logic               alu_wb_valid,
  input  logic [4:0]         alu_wb_rd,
  input  logic signed [31:0] alu_wb_data,
  output logic               alu_wb_ready,
  input  logic               mem_wb_valid,
  input  logic [4:0]         mem_wb_rd,
  input  logic signed [31:0] mem_wb_data,
  output logic               mem_wb_ready,
  output logic               rf_write,
  output logic [4:0]         rf_rd,
  output logic signed [31:0] rf_wdata,
  output logic [31:0]        busy_vec,
  output logic [5:0]         pending_cnt
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  logic [31:0]        busy_q, busy_d;
  logic [5:0]         pending_cnt_q, pending_cnt_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               rf_write_q, rf_write_d;
  logic [4:0]         rf_rd_q, rf_rd_d;
  logic signed [31:0] rf_wdata_q, rf_wdata_d;

  logic               hazard;
  logic               issue_fire;
  logic               alu_gnt;
  logic               mem_gnt;
  logic               wb_gnt;
  logic [4:0]         wb_rd;
  logic signed [31:0] wb_data;

  // Hazard detection and issue handshake, driven only from registered busy bits
  always_comb begin
    hazard      = (issue_use_rs1 && busy_q[issue_rs1]) ||
                  (issue_use_rs2 && busy_q[issue_rs2]) ||
                  (issue_wr      && busy_q[issue_rd]);
    issue_ready = !reset && !hazard;
    issue_fire  = issue_valid && issue_ready;
  end

  // Writeback arbitration: mem has priority unless the ALU has starved long enough
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (reset) begin
      alu_gnt = 1'b0;
      mem_gnt = 1'b0;
    end else if (alu_wb_valid && ((starve_q == LIMIT) || !mem_wb_valid)) begin
      alu_gnt = 1'b1;
    end else if (mem_wb_valid) begin
      mem_gnt = 1'b1;
    end else begin
      alu_gnt = 1'b0;
      mem_gnt = 1'b0;
    end
    wb_gnt       = alu_gnt || mem_gnt;
    wb_rd        = alu_gnt ? alu_wb_rd : mem_wb_rd;
    wb_data      = alu_gnt ? alu_wb_data : mem_wb_data;
    alu_wb_ready = alu_gnt;
    mem_wb_ready = mem_gnt;
  end

  // Starvation counter, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!alu_wb_valid || alu_gnt) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Busy-vector update; a same-cycle issue set on an untracked rd wins over a clear
  always_comb begin
    busy_d = busy_q;
    if (wb_gnt) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_fire && issue_wr) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0]     = 1'b0;
    pending_cnt_d = popcount32(busy_d);
  end

  // Register-file write port next state; rd=0 grants are consumed without writing
  always_comb begin
    rf_write_d = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_gnt) begin
      rf_write_d = (wb_rd != 5'd0);
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end else begin
      rf_write_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= 32'd0;
      pending_cnt_q <= 6'd0;
      starve_q      <= {SW{1'b0}};
      rf_write_q    <= 1'b0;
      rf_rd_q       <= 5'd0;
      rf_wdata_q    <= 32'sd0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
      starve_q      <= starve_d;
      rf_write_q    <= rf_write_d;
      rf_rd_q       <= rf_rd_d;
      rf_wdata_q    <= rf_wdata_d;
    end
  end

  assign busy_vec    = busy_q;
  assign pending_cnt = pending_cnt_q;
  assign rf_write    = rf_write_q;
  assign rf_rd       = rf_rd_q;
  assign rf_wdata    = rf_wdata_q;

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter STARVE_LIMIT, default 2, meaning consecutive lost ALU arbitration cycles before the ALU is forced to win.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 issue_valid  in  1  decode presents an instruction for issue.
REQ-005 issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices.
REQ-006 issue_use_rs1, issue_use_rs2, issue_wr  in  1 each  instruction reads rs1, reads rs2, or writes rd.
REQ-007 issue_ready  out  1  no hazard; issue fires when issue_valid and issue_ready are both 1.
REQ-008 alu_wb_valid, mem_wb_valid  in  1 each  writeback request from the ALU or load path.
REQ-009 alu_wb_rd, mem_wb_rd  in  5 each; alu_wb_data, mem_wb_data  in  32 each (signed)  writeback target and value.
REQ-010 alu_wb_ready, mem_wb_ready  out  1 each  request granted this cycle (combinational).
REQ-011 rf_write  out  1; rf_rd  out  5; rf_wdata  out  32  registered single register-file write port.
REQ-012 busy_vec  out  32  per-register pending-write bits; pending_cnt  out  6  number of set busy bits.

Function
REQ-013 issue_ready SHALL be combinational from the registered busy_vec: 0 if (issue_use_rs1 and busy[rs1]), (issue_use_rs2 and busy[rs2]) or (issue_wr and busy[rd]), else 1; it is independent of issue_valid.
REQ-014 There SHALL be no same-cycle bypass: a grant in cycle N SHALL NOT raise issue_ready before cycle N+1.
REQ-015 On issue fire with issue_wr=1 and rd!=0, busy[rd] SHALL be set at the clock edge.
REQ-016 Register 0 SHALL never be busy; issue with rd=0 SHALL NOT set any bit.
REQ-017 Arbitration SHALL use fixed priority, mem over ALU, except that when the ALU starvation counter equals STARVE_LIMIT and alu_wb_valid=1, the ALU SHALL win.
REQ-018 The starvation counter SHALL increment when alu_wb_valid=1 and the ALU is not granted.
REQ-019 The starvation counter SHALL clear when the ALU is granted or alu_wb_valid=0.
REQ-020 The starvation counter SHALL saturate at STARVE_LIMIT.
REQ-021 At most one of alu_wb_ready or mem_wb_ready SHALL be 1 in a cycle; a requester SHALL hold valid, rd and data until it is granted.
REQ-022 On a grant, the edge SHALL register rf_write=1, rf_rd=winner rd and rf_wdata=winner data, and SHALL clear busy[winner rd].
REQ-023 With no grant, rf_write SHALL register 0 and rf_rd/rf_wdata SHALL hold their values.
REQ-024 A granted writeback with rd=0 SHALL be accepted (ready=1) and SHALL register rf_write=0.
REQ-025 A grant and an issue to the same rd in one cycle cannot both fire, because issue_ready=0 (REQ-013); the implementation SHALL NOT rely on ordering between them.
REQ-026 pending_cnt SHALL equal the popcount of busy_vec every cycle and SHALL be registered alongside it.
REQ-027 A granted writeback to a non-busy rd SHALL still write the register file; busy_vec is unchanged.

Reset
REQ-028 While reset=1 at an edge, busy_vec SHALL become 0, pending_cnt 0, the starvation counter 0, rf_write 0, rf_rd 0 and rf_wdata 0.
REQ-029 Reset SHALL take priority over simultaneous issue and writeback; requests present during reset SHALL be lost; the ready outputs SHALL be 0 while reset=1.
REQ-030 Reset mid-operation with bits busy SHALL clear all bits with no register-file write in the following cycle.

Verification
REQ-031 Issue rd=5, then the next instruction reads rs1=5 -> issue_ready=0 until the edge after mem_wb (rd=5, data=0x0000_00AA) is granted; rf_write=1, rf_rd=5, rf_wdata=0xAA appear in that same next cycle.
REQ-032 alu_wb_valid and mem_wb_valid held high continuously with STARVE_LIMIT=2 -> grants M, M, A, M, M, A; never two readies high at once.
REQ-033 Issue rd=0 with issue_wr=1 -> busy_vec stays 0; mem_wb rd=0 -> mem_wb_ready=1 and rf_write=0 next cycle.
REQ-034 Issue rd=1, 2, 3 in consecutive cycles -> busy_vec=0x0000_000E, pending_cnt=3; ALU writeback to rd=2 -> busy_vec=0x0000_000A, pending_cnt=2.
REQ-035 Assert reset with busy_vec=0x0000_00F0 and both writebacks valid -> next cycle busy_vec=0, pending_cnt=0, rf_write=0, both readies 0 during reset.
REQ-036 Issue reading rs2=7 while busy[7]=1 but issue_use_rs2=0 -> issue_ready=1.
